// File: rtl/axi_ic_wdata_sched.sv
// W-channel scheduler for an AXI slave port: records the master of each accepted AW
// burst and steers the shared W channel to those masters in AW acceptance order.
module axi_ic_wdata_sched #(
    parameter int MSTRNUM = 4,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [MSTRNUM-1:0]         AW_master,
    input  logic                       AWVALID,
    input  logic                       AWREADY,
    output logic                       AWVALID_out,
    output logic                       AWREADY_out,
    input  logic                       WVALID,
    input  logic                       WLAST,
    input  logic                       WREADY,
    output logic                       WVALID_out,
    output logic                       WREADY_out,
    output logic [MSTRNUM-1:0]         W_master,
    output logic [$clog2(DEPTH):0]     pending,
    output logic                       err_onehot
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [MSTRNUM-1:0] mem [DEPTH];
    logic [PW-1:0]      wptr;
    logic [PW-1:0]      rptr;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    // Pointers carry a wrap bit so full and empty are distinguishable without a counter.
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);

    assign AWVALID_out = AWVALID & ~full;
    assign AWREADY_out = AWREADY & ~full;
    assign WVALID_out  = WVALID & ~empty;
    assign WREADY_out  = WREADY & ~empty;

    assign push = AWVALID & AWREADY & ~full;
    assign pop  = WVALID & WREADY & WLAST & ~empty;

    assign W_master = empty ? '0 : mem[rptr[AW-1:0]];
    assign pending  = wptr - rptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr       <= '0;
            rptr       <= '0;
            err_onehot <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wptr[AW-1:0]] <= AW_master;
                wptr              <= wptr + 1'b1;
                if (!$onehot(AW_master)) begin
                    err_onehot <= 1'b1;
                end
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

endmodule

// File: doc/axi_ic_wdata_sched.md
AXI_IC_WDATA_SCHED -- requirements
Module: axi_ic_wdata_sched

Interface
REQ-001 SHALL have parameter MSTRNUM, default 4, number of masters sharing the slave's W channel.
REQ-002 SHALL have parameter DEPTH, default 4, number of outstanding AW bursts tracked; power of two, 2..16.
REQ-003 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port AW_master  input  MSTRNUM  one-hot master currently granted the slave AW channel (from slave arbiter).
REQ-006 SHALL have port AWVALID  input  1  AW valid of the granted master.
REQ-007 SHALL have port AWREADY  input  1  AW ready from slave.
REQ-008 SHALL have port AWVALID_out  output  1  AW valid forwarded to slave.
REQ-009 SHALL have port AWREADY_out  output  1  AW ready returned to master.
REQ-010 SHALL have port WVALID  input  1  W valid of the master selected by W_master.
REQ-011 SHALL have port WLAST  input  1  W last of the selected master.
REQ-012 SHALL have port WREADY  input  1  W ready from slave.
REQ-013 SHALL have port WVALID_out  output  1  W valid forwarded to slave.
REQ-014 SHALL have port WREADY_out  output  1  W ready returned to selected master.
REQ-015 SHALL have port W_master  output  MSTRNUM  one-hot W mux select; all zeros when nothing outstanding.
REQ-016 SHALL have port pending  output  log2(DEPTH)+1  number of AW bursts whose W data is not yet complete.
REQ-017 SHALL have port err_onehot  output  1  sticky flag, AW accepted with AW_master not exactly one-hot.

Function
REQ-018 SHALL hold a FIFO of DEPTH master selects, registered storage, read/write pointers of log2(DEPTH)+1 bits with wrap bit.
REQ-019 SHALL derive full = (pointers differ only in wrap bit) and empty = (pointers equal), both from registered state only.
REQ-020 SHALL drive AWVALID_out = AWVALID & ~full and AWREADY_out = AWREADY & ~full, combinationally.
REQ-021 SHALL push AW_master when AWVALID & AWREADY & ~full; write pointer increments modulo 2*DEPTH.
REQ-022 SHALL drive W_master = FIFO head when ~empty, else all zeros; no bypass, so a push into empty FIFO is visible on W_master the following cycle.
REQ-023 SHALL drive WVALID_out = WVALID & ~empty and WREADY_out = WREADY & ~empty.
REQ-024 SHALL pop when WVALID & WREADY & WLAST & ~empty; W_master advances to the next entry the following cycle.
REQ-025 SHALL push and pop in the same cycle when both conditions hold; pending unchanged.
REQ-026 SHALL, when full, block push even if a pop occurs the same cycle; AW acceptance resumes the next cycle.
REQ-027 SHALL keep pending = write pointer - read pointer (modulo 2*DEPTH), range 0..DEPTH.
REQ-028 SHALL set err_onehot on a push whose AW_master has zero or more than one bit set; entry stored as-is; flag clears only on reset.
REQ-029 SHALL ignore WVALID/WLAST when empty: no pop, no state change.

Reset
REQ-030 SHALL on reset asynchronously clear both pointers, err_onehot and all FIFO entries: W_master=0, pending=0, WVALID_out=0, WREADY_out=0, AWREADY_out=AWREADY.
REQ-031 SHALL discard all outstanding entries on reset asserted mid-burst; first post-reset push becomes the head.

Verification
REQ-032 SHALL verify: reset, AW from master 2 (AW_master=0100) accepted -> next cycle W_master=0100, pending=1; 3-beat W with WLAST on beat 3 -> cycle after beat 3 W_master=0000, pending=0.
REQ-033 SHALL verify: AW order masters 1,3,0 with W delayed -> W_master sequence 0010, 1000, 0001, one change per WLAST handshake.
REQ-034 SHALL verify: DEPTH=4, five AWs with AWREADY=1 and no W -> four accepted, AWREADY_out=0 on fifth, pending=4; one WLAST pop -> fifth accepted next cycle.
REQ-035 SHALL verify: pending=2, simultaneous AW accept and WLAST pop -> pending stays 2, head advances.
REQ-036 SHALL verify: AW accepted with AW_master=0110 -> err_onehot=1 and stays 1 until reset.
REQ-037 SHALL verify: reset asserted mid-W-burst with pending=3 -> W_master=0, pending=0 immediately, WVALID_out=0.
